// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with valid/ready handshake and a two-entry skid buffer.
// The skid entry keeps in_ready a pure flop output, so backpressure never ripples combinationally into fetch.
module if_id_skid_register #(
   parameter int                 PC_W      = 32,
   parameter int                 INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [PC_W-1:0]    in_PC_4,
   input  logic [INSTR_W-1:0] in_Instruction,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_PC_4,
   output logic [INSTR_W-1:0] out_Instruction,
   output logic [CNT_W-1:0]   stall_count
);

   logic               main_valid_q, main_valid_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic               skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [CNT_W-1:0]   stall_count_q, stall_count_d;
   logic               in_fire;
   logic               main_free;

   assign in_ready  = ~skid_valid_q;
   assign in_fire   = in_valid & ~skid_valid_q;
   // Main can take a new beat when it is empty or its beat leaves this cycle.
   assign main_free = ~main_valid_q | out_ready;

   always_comb begin
      main_valid_d  = main_valid_q;
      main_pc_d     = main_pc_q;
      main_instr_d  = main_instr_q;
      skid_valid_d  = skid_valid_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      stall_count_d = stall_count_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else begin
         if (main_free) begin
            if (skid_valid_q) begin
               main_valid_d = 1'b1;
               main_pc_d    = skid_pc_q;
               main_instr_d = skid_instr_q;
               if (in_fire) begin
                  skid_pc_d    = in_PC_4;
                  skid_instr_d = in_Instruction;
               end else begin
                  skid_valid_d = 1'b0;
               end
            end else if (in_fire) begin
               main_valid_d = 1'b1;
               main_pc_d    = in_PC_4;
               main_instr_d = in_Instruction;
            end else begin
               main_valid_d = 1'b0;
            end
         end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = in_PC_4;
            skid_instr_d = in_Instruction;
         end

         if (main_valid_q && !out_ready && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         main_valid_q  <= 1'b0;
         main_pc_q     <= '0;
         main_instr_q  <= NOP_INSTR;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= NOP_INSTR;
         stall_count_q <= '0;
      end else begin
         main_valid_q  <= main_valid_d;
         main_pc_q     <= main_pc_d;
         main_instr_q  <= main_instr_d;
         skid_valid_q  <= skid_valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign out_valid       = main_valid_q;
   assign out_PC_4        = main_valid_q ? main_pc_q : '0;
   assign out_Instruction = main_valid_q ? main_instr_q : NOP_INSTR;
   assign stall_count     = stall_count_q;

endmodule

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
Parametrised IF/ID pipeline register with a valid/ready handshake, replacing the plain enable-gated register between fetch and decode. A two-entry skid buffer gives full throughput with a registered backpressure path. Flush inserts a NOP bubble. A saturating counter reports decode-stall cycles for performance monitoring.

Parameters:
PC_W, 32, width of PC+4 field
INSTR_W, 32, width of instruction field
NOP_INSTR, 32'h0000_0000, instruction value presented when out_valid=0 and after reset or flush
CNT_W, 16, width of stall counter

Ports:
clk  input  1  rising-edge clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
flush  input  1  synchronous flush; discards all held and incoming beats
in_valid  input  1  fetch presents a beat
in_ready  output  1  register accepts a beat this cycle; registered, equals !skid_valid
in_PC_4  input  PC_W  PC+4 of fetched instruction
in_Instruction  input  INSTR_W  fetched instruction
out_valid  output  1  decode-side beat valid
out_ready  input  1  decode accepts beat
out_PC_4  output  PC_W  held PC+4; 0 when out_valid=0
out_Instruction  output  INSTR_W  held instruction; NOP_INSTR when out_valid=0
stall_count  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- State: main entry (main_valid, main_pc, main_instr) and skid entry (skid_valid, skid_pc, skid_instr). out_* driven from main. out_valid = main_valid.
- Transfers: in_fire = in_valid & in_ready. out_fire = main_valid & out_ready.
- Reset (reset=0 at posedge): main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_PC_4=0, out_Instruction=NOP_INSTR, stall_count=0. Reset has priority over flush and all handshakes.
- Flush (flush=1, reset=1): next cycle main_valid=0, skid_valid=0, in_ready=1, outputs at bubble values. An in_fire or out_fire in the flush cycle is ignored: the incoming beat is dropped. stall_count is not incremented in the flush cycle and is not cleared.
- Normal update, evaluated when neither reset nor flush is active:
  - main empty or out_fire:
    - If skid_valid, skid moves into main. In the same cycle, if in_fire, the incoming beat goes into skid. Otherwise skid_valid clears.
    - Otherwise, if in_fire, the incoming beat goes to main. Otherwise main_valid clears.
  - main full and not out_fire:
    - If in_fire, the incoming beat goes into skid and skid_valid=1. in_fire is impossible while skid is full, because in_ready=0.
- Ordering: strict FIFO. No beat is duplicated or lost except by flush.
- Latency: 1 cycle from in_fire to out_valid when the buffer is empty. Throughput is 1 beat/cycle with out_ready held at 1.
- in_ready is a flop, with no combinational path from out_ready. It deasserts the cycle after skid fills and reasserts the cycle after skid drains.
- Data stability: while out_valid=1 and out_ready=0, out_PC_4 and out_Instruction hold constant.
- stall_count increments by 1 per cycle with out_valid=1 & out_ready=0. It saturates at 2^CNT_W-1 with no wrap, and is cleared only by reset.
- Reset mid-transfer: all beats are discarded and stall_count is cleared. Outputs show bubble values from the next cycle.

Test Plan:
- Reset then stream: reset=0 for 2 cycles, then feed PC_4=4,8,12 with Instruction=A,B,C and out_ready=1 -> out_valid rises 1 cycle after first in_fire; outputs (4,A),(8,B),(12,C) on consecutive cycles; in_ready stays 1; stall_count=0.
- Backpressure/skid: out_ready=0 while feeding (4,A),(8,B) -> main=(4,A), skid=(8,B); in_ready=0 one cycle after the skid fill; outputs stable at (4,A); stall_count increments each cycle. Then release out_ready -> (4,A) then (8,B) in order, and in_ready=1 the cycle after skid drains.
- Flush with both entries full plus incoming beat (16,D) in the same cycle -> next cycle out_valid=0, out_PC_4=0, out_Instruction=NOP_INSTR, in_ready=1; D is never output; stall_count is retained.
- Reset and flush asserted together mid-stream with stall_count=5 -> bubble outputs and stall_count=0; reset has priority.
- Saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_count reaches 7 and stays 7.
- Random valid/ready for 2000 beats, with the scoreboard check disabled across flush -> output sequence equals input sequence; data is stable under stall; in_ready never depends combinationally on out_ready.
